// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

    // Arbiter FSM states: searching for a requester, or locked to one burst.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

    // Width of the beat counter, with headroom for the MAX_BURST-1 compare.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Circular priority encoder: first set request strictly after ptr, wrapping.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                any,
    output logic [ID_WIDTH-1:0] idx
);

    int cand;

    // Walk candidates ptr+1 .. ptr+NUM_REQ modulo NUM_REQ; the nearest set bit wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any && (cand == j) && req[j]) begin
                    any = 1'b1;
                    idx = ID_WIDTH'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter driving the async FIFO write port.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = idx_width(NUM_REQ),
    parameter int CNT_WIDTH  = cnt_width(MAX_BURST)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_LAST,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic                          FIFO_FULL,
    output logic                          FIFO_W_INC,
    output logic [DATA_WIDTH-1:0]         FIFO_WR_DATA,
    output logic [ID_WIDTH-1:0]           GNT_ID,
    output logic                          BUSY
);

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   gnt_id;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [CNT_WIDTH-1:0]  beat_cnt;
    logic                  pick_any;
    logic [ID_WIDTH-1:0]   pick_id;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  xfer;
    logic                  burst_end;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req (REQ_VALID),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_id)
    );

    // Select the granted requester's valid/last/data; data is muxed even when idle.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_WIDTH'(i)) begin
                sel_valid = REQ_VALID[i];
                sel_last  = REQ_LAST[i];
                sel_data  = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next state and handshake outputs; READY follows FULL so nothing is written when full.
    always_comb begin
        state_nxt  = state;
        REQ_READY  = '0;
        FIFO_W_INC = 1'b0;
        BUSY       = 1'b0;
        xfer       = 1'b0;
        burst_end  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                BUSY       = 1'b1;
                xfer       = sel_valid & ~FIFO_FULL;
                FIFO_W_INC = xfer;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (gnt_id == ID_WIDTH'(i)) REQ_READY[i] = ~FIFO_FULL;
                end
                burst_end = xfer & (sel_last | (beat_cnt == CNT_WIDTH'(MAX_BURST - 1)));
                if (burst_end) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Grant index, beat counter and round-robin pointer; the pointer moves only at burst end.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gnt_id   <= '0;
            beat_cnt <= '0;
            rr_ptr   <= ID_WIDTH'(NUM_REQ - 1);
        end else if (state == ST_IDLE) begin
            if (pick_any) begin
                gnt_id   <= pick_id;
                beat_cnt <= '0;
            end
        end else if (xfer) begin
            if (burst_end) begin
                beat_cnt <= '0;
                rr_ptr   <= gnt_id;
            end else begin
                beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign FIFO_WR_DATA = sel_data;
    assign GNT_ID       = gnt_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requester models feed the DUT, a monitor checks every FIFO write.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int IW = 2;

    logic            CLK;
    logic            RST;
    logic [N-1:0]    REQ_VALID;
    logic [N*DW-1:0] REQ_DATA;
    logic [N-1:0]    REQ_LAST;
    logic [N-1:0]    REQ_READY;
    logic            FIFO_FULL;
    logic            FIFO_W_INC;
    logic [DW-1:0]   FIFO_WR_DATA;
    logic [IW-1:0]   GNT_ID;
    logic            BUSY;

    int checks = 0;
    int errors = 0;

    logic [DW:0]   src_q [N][$];
    int            exp_id [$];
    logic [DW-1:0] exp_dat [$];
    logic [N-1:0]  acc = '0;

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (N),
        .MAX_BURST  (MB)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .REQ_VALID    (REQ_VALID),
        .REQ_DATA     (REQ_DATA),
        .REQ_LAST     (REQ_LAST),
        .REQ_READY    (REQ_READY),
        .FIFO_FULL    (FIFO_FULL),
        .FIFO_W_INC   (FIFO_W_INC),
        .FIFO_WR_DATA (FIFO_WR_DATA),
        .GNT_ID       (GNT_ID),
        .BUSY         (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    // Present the head of each requester queue on the DUT inputs.
    task automatic drive();
        logic [DW:0] w;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                w = src_q[i][0];
                REQ_VALID[i]              = 1'b1;
                REQ_LAST[i]               = w[DW];
                REQ_DATA[i*DW +: DW]      = w[DW-1:0];
            end else begin
                REQ_VALID[i]              = 1'b0;
                REQ_LAST[i]               = 1'b0;
                REQ_DATA[i*DW +: DW]      = '0;
            end
        end
    endtask

    task automatic src_push(input int r, input logic [DW-1:0] d, input logic last);
        src_q[r].push_back({last, d});
    endtask

    task automatic exp_push(input int id, input logic [DW-1:0] d);
        exp_id.push_back(id);
        exp_dat.push_back(d);
    endtask

    // Main-process timing: inputs change at posedge+2, outputs are read at negedge+1.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic smp();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_id.delete();
        exp_dat.delete();
        drive();
    endtask

    task automatic do_reset();
        tick();
        RST = 1'b0;
        clear_all();
        tick();
        tick();
        RST = 1'b1;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int  n;
        logic pend;
        n = 0;
        pend = 1'b1;
        while (pend && n < budget) begin
            smp();
            n++;
            pend = (exp_id.size() > 0) || BUSY;
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) pend = 1'b1;
        end
        chk({nm, "_drained"}, int'(pend), 0);
    endtask

    // Requester model: retire words the DUT accepted on the previous edge.
    always begin
        @(posedge CLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        acc = '0;
        drive();
    end

    // Monitor: handshake sampling and scoreboard compare of each FIFO write.
    always @(negedge CLK) begin : monitor
        int            ei;
        logic [DW-1:0] ed;
        if (RST) begin
            acc = REQ_VALID & REQ_READY;
            checks++;
            if (!$onehot0(REQ_READY)) begin
                errors++;
                $display("FAIL ready_onehot actual=%b expected=onehot0", REQ_READY);
            end
            if (FIFO_W_INC) begin
                checks++;
                if (FIFO_FULL) begin
                    errors++;
                    $display("FAIL write_while_full actual=1 expected=0");
                end else if (exp_id.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write actual=%0d:%0h expected=none", GNT_ID, FIFO_WR_DATA);
                end else begin
                    ei = exp_id.pop_front();
                    ed = exp_dat.pop_front();
                    if (int'(GNT_ID) != ei || FIFO_WR_DATA != ed) begin
                        errors++;
                        $display("FAIL write_word actual=%0d:%0h expected=%0d:%0h",
                                 GNT_ID, FIFO_WR_DATA, ei, ed);
                    end
                end
            end
        end else begin
            acc = '0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        RST       = 1'b0;
        FIFO_FULL = 1'b0;
        REQ_VALID = '0;
        REQ_DATA  = '0;
        REQ_LAST  = '0;

        // Reset then idle
        repeat (3) smp();
        chk("rst_ready", int'(REQ_READY), 0);
        chk("rst_winc", int'(FIFO_W_INC), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_gnt", int'(GNT_ID), 0);
        tick();
        RST = 1'b1;
        for (int c = 0; c < 10; c++) begin
            smp();
            chk("idle_ready", int'(REQ_READY), 0);
            chk("idle_winc", int'(FIFO_W_INC), 0);
            chk("idle_busy", int'(BUSY), 0);
            chk("idle_gnt", int'(GNT_ID), 0);
        end

        // Single burst from requester 1
        tick();
        src_push(1, 8'hA1, 1'b0); src_push(1, 8'hA2, 1'b0); src_push(1, 8'hA3, 1'b1);
        exp_push(1, 8'hA1); exp_push(1, 8'hA2); exp_push(1, 8'hA3);
        drive();
        smp();
        chk("single_arb_busy", int'(BUSY), 0);
        chk("single_arb_ready", int'(REQ_READY), 0);
        smp();
        chk("single_busy", int'(BUSY), 1);
        chk("single_gnt", int'(GNT_ID), 1);
        chk("single_w1", int'(FIFO_W_INC), 1);
        chk("single_ready", int'(REQ_READY), 4'b0010);
        smp();
        chk("single_w2", int'(FIFO_W_INC), 1);
        smp();
        chk("single_w3", int'(FIFO_W_INC), 1);
        smp();
        chk("single_end_busy", int'(BUSY), 0);
        chk("single_end_winc", int'(FIFO_W_INC), 0);
        chk("single_hold_gnt", int'(GNT_ID), 1);
        wait_drain("single", 10);

        // Round-robin, all four requesters, two bursts of two each
        do_reset();
        for (int i = 0; i < N; i++)
            for (int w = 0; w < 4; w++) src_push(i, 8'(i*16 + w), 1'((w % 2) == 1));
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++)
                for (int k = 0; k < 2; k++) exp_push(i, 8'(i*16 + b*2 + k));
        drive();
        begin
            int writes, idles;
            writes = 0;
            idles  = 0;
            for (int c = 0; c < 24; c++) begin
                smp();
                if (FIFO_W_INC) writes++;
                if (!BUSY) idles++;
            end
            chk("rr_writes", writes, 16);
            chk("rr_idle_cycles", idles, 8);
        end
        smp();
        chk("rr_end_busy", int'(BUSY), 0);
        wait_drain("rr", 10);

        // MAX_BURST cut: req2 six words, req3 two words
        tick();
        for (int w = 1; w <= 6; w++) src_push(2, 8'(8'h20 + w), 1'(w == 6));
        src_push(3, 8'h31, 1'b0); src_push(3, 8'h32, 1'b1);
        for (int w = 1; w <= 4; w++) exp_push(2, 8'(8'h20 + w));
        exp_push(3, 8'h31); exp_push(3, 8'h32);
        exp_push(2, 8'h25); exp_push(2, 8'h26);
        drive();
        wait_drain("maxburst", 40);

        // FULL backpressure for 5 cycles after word 2
        tick();
        for (int w = 1; w <= 4; w++) begin
            src_push(0, 8'(8'h40 + w), 1'(w == 4));
            exp_push(0, 8'(8'h40 + w));
        end
        drive();
        smp();
        smp();
        chk("full_w1", int'(FIFO_W_INC), 1);
        smp();
        chk("full_w2", int'(FIFO_W_INC), 1);
        tick();
        FIFO_FULL = 1'b1;
        for (int c = 0; c < 5; c++) begin
            smp();
            chk("full_winc", int'(FIFO_W_INC), 0);
            chk("full_ready", int'(REQ_READY), 0);
            chk("full_busy", int'(BUSY), 1);
            chk("full_gnt", int'(GNT_ID), 0);
        end
        tick();
        FIFO_FULL = 1'b0;
        smp();
        chk("full_resume", int'(FIFO_W_INC), 1);
        wait_drain("full", 20);

        // Reset mid-burst: req1 loses its grant, req0 joins, search restarts at 0
        tick();
        for (int w = 1; w <= 4; w++) src_push(1, 8'(8'h50 + w), 1'(w == 4));
        src_push(3, 8'h61, 1'b1);
        exp_push(1, 8'h51); exp_push(1, 8'h52);
        drive();
        smp();
        smp();
        chk("mid_w1_gnt", int'(GNT_ID), 1);
        chk("mid_w1", int'(FIFO_W_INC), 1);
        smp();
        chk("mid_w2", int'(FIFO_W_INC), 1);
        tick();
        RST = 1'b0;
        #1;
        chk("mid_rst_ready", int'(REQ_READY), 0);
        chk("mid_rst_winc", int'(FIFO_W_INC), 0);
        chk("mid_rst_busy", int'(BUSY), 0);
        chk("mid_rst_gnt", int'(GNT_ID), 0);
        chk("mid_leftover", src_q[1].size(), 2);
        exp_id.delete();
        exp_dat.delete();
        src_push(0, 8'h71, 1'b1);
        drive();
        exp_push(0, 8'h71);
        exp_push(1, 8'h53); exp_push(1, 8'h54);
        exp_push(3, 8'h61);
        tick();
        tick();
        RST = 1'b1;
        wait_drain("mid_rst", 40);

        chk("scoreboard_empty", exp_id.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
